muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_datapath.sv | 56 +++++
 rtl/muldiv_sequencer.sv | 125 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator for LSB-first shift-add multiply and MSB-first restoring divide.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH:0]   shl;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        acc_nxt  = acc;
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shl      = {acc, 1'b0};
        sub_diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd};
        if (op_div) begin
            // Keep the shifted remainder when the trial subtract goes negative.
            acc_nxt = sub_diff[WIDTH] ? shl[2*WIDTH-1:0]
                                      : {sub_diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
        end else begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, (op_div ? a : b)};
            opnd <= op_div ? b : a;
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, sign fix-up, HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div, dbz, neg_res, neg_rem;
    logic             funct_ok, fn_signed, fn_div, div_zero;
    logic             load, step, fix;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        funct_ok  = (funct == FN_MULT) || (funct == FN_MULTU) ||
                    (funct == FN_DIV)  || (funct == FN_DIVU);
        fn_signed = (funct == FN_MULT) || (funct == FN_DIV);
        fn_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
        div_zero  = fn_div && (rt_data == '0);
        // 0x80..0 negates to itself, which read unsigned is exactly its magnitude.
        mag_a     = (fn_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        mag_b     = (fn_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            IDLE: if (start && funct_ok) begin
                load      = 1'b1;
                state_nxt = div_zero ? FIX : CALC;
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            dbz     <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_nxt;
            done  <= fix;
            if (load) begin
                cnt     <= '0;
                is_div  <= fn_div;
                dbz     <= div_zero;
                neg_res <= fn_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                neg_rem <= fn_signed && fn_div && rs_data[WIDTH-1];
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (fix) begin
                hi <= hi_nxt;
                lo <= lo_nxt;
            end
        end
    end

    // Divide by zero restores the dividend from its loaded magnitude via the dividend sign.
    always_comb begin
        prod   = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        hi_nxt = prod[2*WIDTH-1:WIDTH];
        lo_nxt = prod[WIDTH-1:0];
        if (dbz) begin
            hi_nxt = neg_rem ? -acc_lo : acc_lo;
            lo_nxt = '1;
        end else if (is_div) begin
            hi_nxt = neg_rem ? -acc_hi : acc_hi;
            lo_nxt = neg_res ? -acc_lo : acc_lo;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .op_div (load ? fn_div : is_div),
        .a      (mag_a),
        .b      (mag_b),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    assign busy  = (state != IDLE);
    assign stall = busy && (hilo_read || start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: arithmetic reference model plus directed vectors with literal results.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         hilo_read = 1'b0;
    logic [5:0]   funct = '0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference model state: result appears a fixed number of edges after acceptance.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct     (funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hilo_read (hilo_read),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit valid_funct(input logic [5:0] f);
        return (f == 6'h18) || (f == 6'h19) || (f == 6'h1A) || (f == 6'h1B);
    endfunction

    // Returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        longint      q, r;
        logic [63:0] res;
        res = '0;
        case (f)
            6'h18: res = 64'(sa * sb);
            6'h19: res = ua * ub;
            6'h1A: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            6'h1B: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
                m_left <= m_left - 1;
            end else if (start && valid_funct(funct)) begin
                {p_hi, p_lo} <= model_result(funct, rs_data, rt_data);
                m_left       <= (funct[1] && rt_data == 0) ? 1 : W + 1;
                m_busy       <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",  32'(busy),  32'(m_busy));
            check("done",  32'(done),  32'(m_done));
            check("stall", 32'(stall), 32'(m_busy && (hilo_read || start)));
            check("hi",    hi, m_hi);
            check("lo",    lo, m_lo);
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step_cyc();
            n++;
        end
    endtask

    // Called 2 time units after an edge with the sequencer idle; issues one operation.
    task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat);
        int n;
        start   = 1'b1;
        funct   = f;
        rs_data = a;
        rt_data = b;
        step_cyc();
        start = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, n, elat);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_model_hi"}, m_hi, ehi);
        check({tag, "_model_lo"}, m_lo, elo);
    endtask

    initial begin
        int n;
        int dc;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);
        check("rst_stall", 32'(stall), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        step_cyc();

        do_op("mult_7_m3",   6'h18, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        do_op("multu_7_m3",  6'h19, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB, 33);
        do_op("div_m7_2",    6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        do_op("divu_100_7",  6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        do_op("div_5_0",     6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        do_op("div_m7_0",    6'h1A, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        do_op("div_min_m1",  6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        do_op("mult_min_min",6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
        do_op("divu_max_1",  6'h1B, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 33);
        do_op("multu_max",   6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33);

        // Unrecognised funct must leave the sequencer idle.
        start   = 1'b1;
        funct   = 6'h20;
        rs_data = 32'd1;
        rt_data = 32'd2;
        step_cyc();
        step_cyc();
        check("bad_funct_busy", 32'(busy), 0);
        start = 1'b0;
        step_cyc();

        // Stall on mfhi/mflo and a second start while busy.
        start   = 1'b1;
        funct   = 6'h18;
        rs_data = 32'd7;
        rt_data = 32'hFFFF_FFFD;
        step_cyc();
        start = 1'b0;
        repeat (5) step_cyc();
        hilo_read = 1'b1;
        start     = 1'b1;
        funct     = 6'h1B;
        rs_data   = 32'd100;
        rt_data   = 32'd7;
        #1;
        check("stall_calc", 32'(stall), 1);
        #1;
        repeat (5) step_cyc();
        start = 1'b0;
        wait_done(n);
        check("stall_latency", n, 23);
        check("stall_done_cycle", 32'(stall), 0);
        check("stall_hi", hi, 32'hFFFF_FFFF);
        check("stall_lo", lo, 32'hFFFF_FFEB);
        hilo_read = 1'b0;
        step_cyc();
        check("second_start_ignored", 32'(busy), 0);

        // Reset in the middle of an operation.
        start   = 1'b1;
        funct   = 6'h19;
        rs_data = 32'h1234_5678;
        rt_data = 32'h10;
        step_cyc();
        start = 1'b0;
        repeat (10) step_cyc();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        #1;
        step_cyc();
        step_cyc();
        rst_n = 1'b1;
        dc = 0;
        repeat (40) begin
            step_cyc();
            if (done === 1'b1) dc++;
        end
        check("abort_no_done", dc, 0);
        do_op("after_abort", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        step_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
